// File: rtl/burst_sdr_peer_if.sv
// rtl/burst_sdr_peer_if.sv - CNT/SP line pair plus TX/RX byte handshakes of the burst SDR peer
interface burst_sdr_peer_if;

  // open-drain line pair: levels in, pull-down enables out
  logic       cnt_in;
  logic       cnt_oe;
  logic       sp_in;
  logic       sp_oe;

  // direction select
  logic       dir_tx;

  // transmit byte handshake
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  // receive byte handshake and status
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ack;
  logic       rx_overrun;
  logic       busy;

  // the side that drives the peer (bench, host logic)
  modport master (
    output cnt_in, sp_in, dir_tx, tx_data, tx_valid, rx_ack,
    input  cnt_oe, sp_oe, tx_ready, rx_data, rx_valid, rx_overrun, busy
  );

  // the peer itself
  modport slave (
    input  cnt_in, sp_in, dir_tx, tx_data, tx_valid, rx_ack,
    output cnt_oe, sp_oe, tx_ready, rx_data, rx_valid, rx_overrun, busy
  );

endinterface

// File: rtl/burst_sdr_peer.sv
// rtl/burst_sdr_peer.sv - drive-side burst serial peer; optional RX timeout via BURST_PEER_RX_TIMEOUT_EN
module burst_sdr_peer #(
  parameter int HALF_PERIOD = 8,
  parameter int TIMEOUT     = 255
) (
  input  logic              E_CLK,
  input  logic              RESET_n,
  burst_sdr_peer_if.slave   bus
);

  typedef enum logic [1:0] {
    TX_IDLE = 2'd0,
    TX_LOW  = 2'd1,
    TX_HIGH = 2'd2
  } tx_state_t;

  localparam logic [7:0] DIV_LAST = 8'(HALF_PERIOD - 1);

  // line synchronisers; reset to the pulled-up idle level so release of
  // reset never looks like a CNT rising edge
  logic       cnt_s1;
  logic       cnt_s2;
  logic       cnt_prev;
  logic       sp_s1;
  logic       sp_s2;
  logic       cnt_rise;

  // receive path
  logic [6:0] rx_shift;
  logic [2:0] rx_bits;
  logic [7:0] rx_byte_nxt;
  logic [7:0] rx_data_q;
  logic       rx_valid_q;
  logic       rx_overrun_q;
  logic       rx_timeout;

  // transmit path
  tx_state_t  tx_state;
  tx_state_t  tx_state_nxt;
  logic [7:0] tx_shift;
  logic [7:0] tx_shift_nxt;
  logic [2:0] tx_bit;
  logic [2:0] tx_bit_nxt;
  logic [7:0] div;
  logic [7:0] div_nxt;
  logic       div_done;
  logic       tx_ready_c;
  logic       cnt_oe_c;
  logic       sp_oe_c;

  // two-stage synchronisers plus the previous CNT sample for edge detection
  always_ff @(posedge E_CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      cnt_s1   <= 1'b1;
      cnt_s2   <= 1'b1;
      cnt_prev <= 1'b1;
      sp_s1    <= 1'b1;
      sp_s2    <= 1'b1;
    end else begin
      cnt_s1   <= bus.cnt_in;
      cnt_s2   <= cnt_s1;
      cnt_prev <= cnt_s2;
      sp_s1    <= bus.sp_in;
      sp_s2    <= sp_s1;
    end
  end

  assign cnt_rise    = cnt_s2 & ~cnt_prev;
  assign rx_byte_nxt = {rx_shift, sp_s2};

`ifdef BURST_PEER_RX_TIMEOUT_EN
  localparam int            TO_W    = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT);

  logic [TO_W-1:0] to_cnt;

  // cycles since the last CNT rise while a partial byte is pending
  always_ff @(posedge E_CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      to_cnt <= '0;
    end else if (bus.dir_tx || cnt_rise || (rx_bits == 3'd0)) begin
      to_cnt <= '0;
    end else if (to_cnt != TO_LAST) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  assign rx_timeout = (to_cnt == TO_LAST);
`else
  // without the timeout a partial byte waits for more edges or dir_tx=1
  assign rx_timeout = 1'b0;
`endif

  // receive shifter, byte completion, valid/overrun bookkeeping
  always_ff @(posedge E_CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      rx_shift     <= '0;
      rx_bits      <= '0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      rx_overrun_q <= 1'b0;
    end else begin
      // ack first so a byte completing in the same cycle keeps rx_valid set
      if (bus.rx_ack) begin
        rx_valid_q <= 1'b0;
      end
      if (bus.dir_tx) begin
        // we own CNT while transmitting; any partial byte is dropped
        rx_shift <= '0;
        rx_bits  <= '0;
      end else if (cnt_rise) begin
        rx_shift <= rx_byte_nxt[6:0];
        rx_bits  <= rx_bits + 3'd1;
        if (rx_bits == 3'd7) begin
          rx_data_q  <= rx_byte_nxt;
          rx_valid_q <= 1'b1;
          if (rx_valid_q && !bus.rx_ack) begin
            rx_overrun_q <= 1'b1;
          end
        end
      end else if (rx_timeout) begin
        rx_shift <= '0;
        rx_bits  <= '0;
      end
    end
  end

  // transmit state, divider, bit counter and data shifter registers
  always_ff @(posedge E_CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      tx_state <= TX_IDLE;
      tx_shift <= '0;
      tx_bit   <= '0;
      div      <= '0;
    end else begin
      tx_state <= tx_state_nxt;
      tx_shift <= tx_shift_nxt;
      tx_bit   <= tx_bit_nxt;
      div      <= div_nxt;
    end
  end

  assign div_done = (div == DIV_LAST);

  // transmit next-state and line drive: CNT low phase presents the bit,
  // high phase holds it steady across the rising edge the cartridge samples on
  always_comb begin
    tx_state_nxt = tx_state;
    tx_shift_nxt = tx_shift;
    tx_bit_nxt   = tx_bit;
    div_nxt      = div;
    tx_ready_c   = 1'b0;
    cnt_oe_c     = 1'b0;
    sp_oe_c      = 1'b0;

    case (tx_state)
      TX_IDLE: begin
        tx_ready_c = 1'b1;
        if (bus.tx_valid) begin
          tx_shift_nxt = bus.tx_data;
          tx_bit_nxt   = 3'd0;
          div_nxt      = 8'd0;
          tx_state_nxt = TX_LOW;
        end
      end

      TX_LOW: begin
        cnt_oe_c = 1'b1;
        sp_oe_c  = ~tx_shift[7];
        if (div_done) begin
          div_nxt      = 8'd0;
          tx_state_nxt = TX_HIGH;
        end else begin
          div_nxt = div + 8'd1;
        end
      end

      TX_HIGH: begin
        sp_oe_c = ~tx_shift[7];
        if (div_done) begin
          div_nxt = 8'd0;
          if (tx_bit == 3'd7) begin
            // last half-period of the byte doubles as an accept slot so
            // consecutive bytes stream with no idle gap
            tx_ready_c = 1'b1;
            if (bus.tx_valid) begin
              tx_shift_nxt = bus.tx_data;
              tx_bit_nxt   = 3'd0;
              tx_state_nxt = TX_LOW;
            end else begin
              tx_state_nxt = TX_IDLE;
            end
          end else begin
            tx_shift_nxt = {tx_shift[6:0], 1'b0};
            tx_bit_nxt   = tx_bit + 3'd1;
            tx_state_nxt = TX_LOW;
          end
        end else begin
          div_nxt = div + 8'd1;
        end
      end

      default: begin
        tx_state_nxt = TX_IDLE;
        div_nxt      = 8'd0;
      end
    endcase

    // leaving transmit direction aborts immediately and never drives the lines
    if (!bus.dir_tx) begin
      tx_state_nxt = TX_IDLE;
      tx_bit_nxt   = 3'd0;
      div_nxt      = 8'd0;
      tx_ready_c   = 1'b0;
      cnt_oe_c     = 1'b0;
      sp_oe_c      = 1'b0;
    end
  end

  assign bus.cnt_oe     = cnt_oe_c;
  assign bus.sp_oe      = sp_oe_c;
  assign bus.tx_ready   = tx_ready_c;
  assign bus.rx_data    = rx_data_q;
  assign bus.rx_valid   = rx_valid_q;
  assign bus.rx_overrun = rx_overrun_q;
  assign bus.busy       = (tx_state != TX_IDLE) || (rx_bits != 3'd0);

endmodule
